// File: rtl/melody_pkg.sv
// Shared constants for the melody sequencer: pitch codes, divider half-periods,
// FSM states and the song table layout with its default tune.
package melody_pkg;

  localparam int PITCH_W   = 4;
  localparam int DUR_W     = 10;
  localparam int ENTRY_W   = PITCH_W + DUR_W;
  localparam int MAX_STEPS = 16;
  localparam int HP_W      = 17;

  // Entry layout is {pitch, dur_ticks}; index i holds step i.
  typedef logic [MAX_STEPS-1:0][ENTRY_W-1:0] song_table_t;

  localparam logic [PITCH_W-1:0] P_REST = 4'd0;
  localparam logic [PITCH_W-1:0] P_C5   = 4'd1;
  localparam logic [PITCH_W-1:0] P_D5   = 4'd2;
  localparam logic [PITCH_W-1:0] P_E5   = 4'd3;
  localparam logic [PITCH_W-1:0] P_F5   = 4'd4;
  localparam logic [PITCH_W-1:0] P_G5   = 4'd5;
  localparam logic [PITCH_W-1:0] P_A5   = 4'd6;
  localparam logic [PITCH_W-1:0] P_B5   = 4'd7;
  localparam logic [PITCH_W-1:0] P_C6   = 4'd8;

  // Codes 9..15 are unused and map to 0, which the FSM treats as a rest.
  localparam logic [HP_W-1:0] HP_TABLE [0:15] = '{
    17'd0,     17'd47778, 17'd42566, 17'd37921,
    17'd35793, 17'd31888, 17'd28409, 17'd25310,
    17'd23889, 17'd0,     17'd0,     17'd0,
    17'd0,     17'd0,     17'd0,     17'd0
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_e;

  function automatic logic [HP_W-1:0] hp_of(input logic [PITCH_W-1:0] p);
    return HP_TABLE[p];
  endfunction

  function automatic song_table_t default_song();
    song_table_t t;
    t = '0;
    for (int i = 0; i < 8; i++) t[i] = {PITCH_W'(i + 1), DUR_W'(250)};
    return t;
  endfunction

  localparam song_table_t DEFAULT_SONG = default_song();

endpackage

// File: rtl/melody_sequencer_tone_divider.sv
// Programmable square-wave generator: counts 0..hp, toggling the output on each
// wrap, so one half-period is hp+1 clocks.
module tone_divider
  import melody_pkg::*;
(
  input  logic            clk_50MHz,
  input  logic            reset,
  input  logic            en,
  input  logic            clr,
  input  logic [HP_W-1:0] hp,
  output logic            tone
);

  logic [HP_W-1:0] cnt_q, cnt_d;
  logic            tone_q, tone_d;

  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (clr) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (en) begin
      if (cnt_q == hp) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d = cnt_q + HP_W'(1);
      end
    end
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/melody_sequencer.sv
// Song player: walks the song table, drives one tone divider per note, times note
// and inter-note gap lengths with a tick prescaler, and handles start/stop/loop.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned GAP_TICKS  = 10,
  parameter int unsigned SONG_LEN   = 8,
  parameter song_table_t SONG_TABLE = DEFAULT_SONG
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  output logic       tone_out,
  output logic       busy,
  output logic [3:0] step_idx,
  output logic       done
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] GAP_TGT   = DUR_W'(GAP_TICKS);
  localparam logic [3:0]       STEP_LAST = 4'(SONG_LEN - 1);

  state_e            state_q, state_d;
  logic [3:0]        step_q, step_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [DUR_W-1:0]  dcnt_q, dcnt_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ENTRY_W-1:0] cur_entry;
  logic [DUR_W-1:0]   span_tgt;
  logic               tick_wrap;
  logic               span_end;
  logic               div_en;
  logic               div_clr;

  assign cur_entry = SONG_TABLE[step_q];
  assign tick_wrap = (tick_q == TICK_LAST);
  assign span_tgt  = (state_q == S_GAP) ? GAP_TGT : dur_q;
  // A zero-length span ends in its first cycle; otherwise on the wrap of its last tick.
  assign span_end  = (span_tgt == '0) ||
                     (tick_wrap && (dcnt_q == span_tgt - DUR_W'(1)));

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tick_d  = tick_q;
    dcnt_d  = dcnt_q;
    dur_d   = dur_q;
    hp_d    = hp_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          step_d  = '0;
        end
      end
      S_LOAD: begin
        hp_d    = hp_of(cur_entry[ENTRY_W-1:DUR_W]);
        dur_d   = cur_entry[DUR_W-1:0];
        tick_d  = '0;
        dcnt_d  = '0;
        state_d = S_PLAY;
      end
      S_PLAY, S_GAP: begin
        tick_d = tick_wrap ? '0 : tick_q + TW'(1);
        dcnt_d = tick_wrap ? dcnt_q + DUR_W'(1) : dcnt_q;
        if (span_end) begin
          tick_d = '0;
          dcnt_d = '0;
          if (state_q == S_PLAY) begin
            state_d = S_GAP;
          end else if (step_q != STEP_LAST) begin
            step_d  = step_q + 4'd1;
            state_d = S_LOAD;
          end else if (loop_en) begin
            step_d  = '0;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        step_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
    // stop overrides everything, including a simultaneous start from IDLE
    if (stop) begin
      state_d = S_IDLE;
      step_d  = '0;
      tick_d  = '0;
      dcnt_d  = '0;
    end
    // busy drops in the DONE cycle so it falls together with the done pulse
    busy_d = (state_d == S_LOAD) || (state_d == S_PLAY) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      tick_q  <= '0;
      dcnt_q  <= '0;
      dur_q   <= '0;
      hp_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      tick_q  <= tick_d;
      dcnt_q  <= dcnt_d;
      dur_q   <= dur_d;
      hp_q    <= hp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Clear is driven from the next state so the tone is already low in the
  // first cycle after PLAY is left, whether by GAP or by stop.
  assign div_en  = (state_q == S_PLAY);
  assign div_clr = (state_d != S_PLAY) || (hp_q == '0);

  tone_divider u_tone (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .en        (div_en),
    .clr       (div_clr),
    .hp        (hp_q),
    .tone      (tone_out)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = step_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer using a short 5-step song with a rest,
// a zero-length note and one long C6 note that actually toggles the buzzer.
module tb_melody_sequencer;
  import melody_pkg::*;

  localparam int TD = 50;
  localparam int GT = 2;
  localparam int SL = 5;
  // LOAD-relative cycle where DONE (or the loop restart) lands:
  // 301 + 301 + 601 + (1+23950+100) + (1+1+100)
  localparam int SONG_CYC = 25356;

  function automatic song_table_t tb_song();
    song_table_t t;
    t    = '0;
    t[0] = {P_C5,   10'd4};
    t[1] = {P_REST, 10'd4};
    t[2] = {P_D5,   10'd10};
    t[3] = {P_C6,   10'd479};
    t[4] = {P_E5,   10'd0};
    return t;
  endfunction

  localparam song_table_t TB_SONG = tb_song();

  logic       clk_50MHz = 1'b0;
  logic       reset     = 1'b1;
  logic       start     = 1'b0;
  logic       stop      = 1'b0;
  logic       loop_en   = 1'b0;
  logic       tone_out;
  logic       busy;
  logic [3:0] step_idx;
  logic       done;

  int checks   = 0;
  int failures = 0;

  melody_sequencer #(
    .TICK_DIV   (TD),
    .GAP_TICKS  (GT),
    .SONG_LEN   (SL),
    .SONG_TABLE (TB_SONG)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .tone_out  (tone_out),
    .busy      (busy),
    .step_idx  (step_idx),
    .done      (done)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk_50MHz);
    #1;
  endtask

  initial begin
    int bad, rise_t, fall_t, done_n, done_t;

    // reset values and a quiet idle period
    repeat (3) tick();
    chk("rst_tone", tone_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step", step_idx, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (tone_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || step_idx !== 4'd0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // full song, no loop
    loop_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_step", step_idx, 0);
    rise_t = -1; fall_t = -1; done_n = 0; done_t = -1;
    for (int t = 1; t <= SONG_CYC + 20; t++) begin
      tick();
      if (tone_out === 1'b1 && rise_t < 0) rise_t = t;
      if (tone_out === 1'b0 && rise_t >= 0 && fall_t < 0) fall_t = t;
      if (done === 1'b1) begin
        done_n++;
        if (done_t < 0) done_t = t;
      end
      if (t == 300)          chk("s0_last_gap", step_idx, 0);
      if (t == 301)          chk("s1_load", step_idx, 1);
      if (t == 400)          chk("rest_tone", tone_out, 0);
      if (t == 602)          chk("s2_load", step_idx, 2);
      if (t == 1203)         chk("s3_load", step_idx, 3);
      if (t == 25254)        chk("s4_load", step_idx, 4);
      if (t == 25255)        chk("dur0_busy", busy, 1);
      if (t == SONG_CYC - 1) chk("busy_pre_done", busy, 1);
      if (t == SONG_CYC)     chk("busy_at_done", busy, 0);
    end
    chk("tone_rise_t", rise_t, 25094);
    chk("tone_fall_t", fall_t, 25154);
    chk("done_t", done_t, SONG_CYC);
    chk("done_count", done_n, 1);

    // loop wrap, ignored start while busy, then stop while the tone is high
    loop_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    done_n = 0;
    for (int t = 1; t <= 50470; t++) begin
      tick();
      start = 1'b0;
      stop  = 1'b0;
      if (done === 1'b1) done_n++;
      if (t == SONG_CYC - 1)   chk("loop_last_step", step_idx, 4);
      if (t == SONG_CYC)       chk("loop_wrap_step", step_idx, 0);
      if (t == SONG_CYC)       chk("loop_wrap_busy", busy, 1);
      if (t == SONG_CYC + 400) start = 1'b1;
      if (t == SONG_CYC + 602) chk("start_ignored", step_idx, 2);
      if (t == 50460) begin
        chk("pre_stop_tone", tone_out, 1);
        stop = 1'b1;
      end
      if (t == 50461) begin
        chk("stop_busy", busy, 0);
        chk("stop_tone", tone_out, 0);
        chk("stop_step", step_idx, 0);
      end
    end
    chk("loop_no_done", done_n, 0);
    loop_en = 1'b0;

    // start and stop together from IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("both_busy", busy, 0);
    tick();
    chk("both_busy2", busy, 0);
    chk("both_step", step_idx, 0);

    // asynchronous reset in the middle of step 1
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (350) tick();
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_step", step_idx, 1);
    #3 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_step", step_idx, 0);
    chk("arst_tone", tone_out, 0);
    chk("arst_done", done, 0);
    tick();
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("post_rst_quiet", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
